vx_issue_sched: RTL and testbench

- Multi-warp issue scheduler; successor to the single-stream issue stage.
- Accepts one decoded instruction head per warp from per-warp instruction buffers.
- Tracks per-warp pending destination registers in an internal scoreboard and selects one hazard-free warp per cycle, round-robin.
- Drives a registered output slot addressed to one of NUM_EX execution units. Operand fetch and dispatch sit downstream.

---
 rtl/vx_issue_sched.sv | 176 +++++++++++++++++
 tb/tb_vx_issue_sched.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_issue_sched.sv
// vx_issue_sched: round-robin multi-warp issue stage with a per-warp pending-register scoreboard.
// Optional performance counters are built in when VX_ISSUE_SCHED_PERF_EN is defined.
module vx_issue_sched #(
    parameter int NUM_WARPS     = 4,
    parameter int NUM_REGS      = 64,
    parameter int NUM_EX        = 5,
    parameter int DATA_W        = 128,
    parameter int PERF_CTR_BITS = 44,
    localparam int RW  = $clog2(NUM_REGS),
    localparam int EXW = $clog2(NUM_EX),
    localparam int WW  = $clog2(NUM_WARPS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_WARPS-1:0]        in_valid,
    output logic [NUM_WARPS-1:0]        in_ready,
    input  logic [NUM_WARPS-1:0]        in_wb,
    input  logic [NUM_WARPS*RW-1:0]     in_rd,
    input  logic [NUM_WARPS*3*RW-1:0]   in_rs,
    input  logic [NUM_WARPS*3-1:0]      in_rs_use,
    input  logic [NUM_WARPS*EXW-1:0]    in_ex_type,
    input  logic [NUM_WARPS*DATA_W-1:0] in_data,
    input  logic                        wb_valid,
    input  logic [WW-1:0]               wb_wid,
    input  logic [RW-1:0]               wb_rd,
    input  logic                        wb_eop,
    output logic [NUM_EX-1:0]           out_valid,
    input  logic [NUM_EX-1:0]           out_ready,
    output logic [WW-1:0]               out_wid,
    output logic                        out_wb,
    output logic [RW-1:0]               out_rd,
    output logic [DATA_W-1:0]           out_data
`ifdef VX_ISSUE_SCHED_PERF_EN
    ,
    output logic [PERF_CTR_BITS-1:0]    perf_issued,
    output logic [PERF_CTR_BITS-1:0]    perf_scb_stalls,
    output logic [PERF_CTR_BITS-1:0]    perf_unit_stalls
`endif
);

    if (NUM_WARPS < 2 || (NUM_WARPS & (NUM_WARPS - 1)) != 0 || PERF_CTR_BITS < 1) begin : g_bad_params
        $error("vx_issue_sched: NUM_WARPS must be a power of two >= 2 and PERF_CTR_BITS >= 1");
    end

    // Handshakes: a head transfers when in_valid[w] & in_ready[w]; the slot
    // transfers when out_valid[e] & out_ready[e]. Valid never waits on ready.
    logic [NUM_WARPS-1:0][NUM_REGS-1:0] pending;
    logic [WW-1:0]       ptr;
    logic [NUM_WARPS-1:0] hazard;
    logic [NUM_WARPS-1:0] eligible;
    logic                slot_free;
    logic                slot_drain;
    logic                win_valid;
    logic [WW-1:0]       win_idx;
    logic [WW-1:0]       cand;
    logic                win_wb;
    logic [RW-1:0]       win_rd;
    logic [EXW-1:0]      win_ex;
    logic [DATA_W-1:0]   win_data;
    logic [NUM_EX-1:0]   win_onehot;
    logic [RW-1:0]       rs_idx;
    logic [RW-1:0]       rd_idx;

    always_comb begin
        hazard = '0;
        rs_idx = '0;
        rd_idx = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            for (int k = 0; k < 3; k++) begin
                rs_idx = in_rs[(w*3+k)*RW +: RW];
                if (in_rs_use[w*3+k] && rs_idx != '0 && pending[w][rs_idx])
                    hazard[w] = 1'b1;
            end
            rd_idx = in_rd[w*RW +: RW];
            if (in_wb[w] && rd_idx != '0 && pending[w][rd_idx])
                hazard[w] = 1'b1;
        end
    end

    assign slot_drain = (out_valid & out_ready) != '0;
    assign slot_free  = (out_valid == '0) || slot_drain;
    assign eligible   = in_valid & ~hazard & {NUM_WARPS{slot_free}};

    // Scan starts just after the last winner; the index wraps by truncation.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_WARPS; i++) begin
            cand = ptr + WW'(i);
            if (!win_valid && eligible[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        win_wb     = 1'b0;
        win_rd     = '0;
        win_ex     = '0;
        win_data   = '0;
        in_ready   = '0;
        win_onehot = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (win_idx == WW'(w)) begin
                win_wb   = in_wb[w];
                win_rd   = in_rd[w*RW +: RW];
                win_ex   = in_ex_type[w*EXW +: EXW];
                win_data = in_data[w*DATA_W +: DATA_W];
            end
            in_ready[w] = win_valid && !reset && (win_idx == WW'(w));
        end
        for (int e = 0; e < NUM_EX; e++)
            win_onehot[e] = (win_ex == EXW'(e));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending   <= '0;
            ptr       <= WW'(NUM_WARPS - 1);
            out_valid <= '0;
            out_wid   <= '0;
            out_wb    <= 1'b0;
            out_rd    <= '0;
            out_data  <= '0;
        end else begin
            // Clear precedes set so a same-bit set would win.
            if (wb_valid && wb_eop)
                pending[wb_wid][wb_rd] <= 1'b0;
            if (win_valid) begin
                if (win_wb && win_rd != '0)
                    pending[win_idx][win_rd] <= 1'b1;
                ptr       <= win_idx;
                out_valid <= win_onehot;
                out_wid   <= win_idx;
                out_wb    <= win_wb;
                out_rd    <= win_rd;
                out_data  <= win_data;
            end else if (slot_drain) begin
                out_valid <= '0;
            end
        end
    end

`ifdef VX_ISSUE_SCHED_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_issued      <= '0;
            perf_scb_stalls  <= '0;
            perf_unit_stalls <= '0;
        end else begin
            if (win_valid)
                perf_issued <= perf_issued + 1'b1;
            if ((in_valid != '0) && slot_free && (eligible == '0))
                perf_scb_stalls <= perf_scb_stalls + 1'b1;
            if ((out_valid != '0) && !slot_drain)
                perf_unit_stalls <= perf_unit_stalls + 1'b1;
        end
    end
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset) begin
            assert ($onehot0(in_ready)) else $error("vx_issue_sched: in_ready not one-hot");
            assert ($onehot0(out_valid)) else $error("vx_issue_sched: out_valid not one-hot");
            if (win_valid)
                assert (int'(win_ex) < NUM_EX) else $error("vx_issue_sched: ex_type out of range");
            if (wb_valid && wb_eop && wb_rd != '0)
                assert (pending[wb_wid][wb_rd]) else $error("vx_issue_sched: writeback to idle register");
        end
    end
`endif

endmodule

// File: tb/tb_vx_issue_sched.sv
// Bench for vx_issue_sched: directed scenarios followed by random traffic, all checked
// against a behavioural scheduler model and a payload scoreboard.
module tb_vx_issue_sched;
    localparam int NW  = 4;
    localparam int NR  = 64;
    localparam int NE  = 5;
    localparam int DW  = 128;
    localparam int RW  = 6;
    localparam int EXW = 3;
    localparam int WW  = 2;
    localparam int PB  = 44;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NW-1:0]      in_valid, in_ready, in_wb;
    logic [NW*RW-1:0]   in_rd;
    logic [NW*3*RW-1:0] in_rs;
    logic [NW*3-1:0]    in_rs_use;
    logic [NW*EXW-1:0]  in_ex_type;
    logic [NW*DW-1:0]   in_data;
    logic               wb_valid, wb_eop;
    logic [WW-1:0]      wb_wid;
    logic [RW-1:0]      wb_rd;
    logic [NE-1:0]      out_valid, out_ready;
    logic [WW-1:0]      out_wid;
    logic               out_wb;
    logic [RW-1:0]      out_rd;
    logic [DW-1:0]      out_data;
`ifdef VX_ISSUE_SCHED_PERF_EN
    logic [PB-1:0]      perf_issued, perf_scb_stalls, perf_unit_stalls;
`endif

    vx_issue_sched dut (
        .clk(clk), .reset(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_wb(in_wb), .in_rd(in_rd),
        .in_rs(in_rs), .in_rs_use(in_rs_use), .in_ex_type(in_ex_type), .in_data(in_data),
        .wb_valid(wb_valid), .wb_wid(wb_wid), .wb_rd(wb_rd), .wb_eop(wb_eop),
        .out_valid(out_valid), .out_ready(out_ready), .out_wid(out_wid),
        .out_wb(out_wb), .out_rd(out_rd), .out_data(out_data)
`ifdef VX_ISSUE_SCHED_PERF_EN
        , .perf_issued(perf_issued), .perf_scb_stalls(perf_scb_stalls),
        .perf_unit_stalls(perf_unit_stalls)
`endif
    );

    // Per-warp head registers, packed onto the flat DUT buses.
    logic           v_valid [NW];
    logic           v_wb    [NW];
    logic [RW-1:0]  v_rd    [NW];
    logic [RW-1:0]  v_rs    [NW][3];
    logic           v_use   [NW][3];
    logic [EXW-1:0] v_ex    [NW];
    logic [DW-1:0]  v_data  [NW];

    always_comb begin
        in_valid = '0; in_wb = '0; in_rd = '0; in_rs = '0;
        in_rs_use = '0; in_ex_type = '0; in_data = '0;
        for (int w = 0; w < NW; w++) begin
            in_valid[w] = v_valid[w];
            in_wb[w]    = v_wb[w];
            in_rd[w*RW +: RW] = v_rd[w];
            in_ex_type[w*EXW +: EXW] = v_ex[w];
            in_data[w*DW +: DW] = v_data[w];
            for (int k = 0; k < 3; k++) begin
                in_rs[(w*3+k)*RW +: RW] = v_rs[w][k];
                in_rs_use[w*3+k] = v_use[w][k];
            end
        end
    end

    // Reference model state.
    bit            m_pend [NW][NR];
    int            m_ptr, m_win;
    logic [NE-1:0] m_ov;
    logic [WW-1:0] m_wid;
    logic          m_wb;
    logic [RW-1:0] m_rd;
    logic [DW-1:0] m_data;
    longint        m_issued, m_scb, m_unit;
    logic [DW-1:0] exp_q [$];
    int            pq [$];
    int            checks, errors;
    logic [DW-1:0] held;
    int            order [5] = '{0, 1, 2, 3, 0};

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        for (int w = 0; w < NW; w++)
            for (int r = 0; r < NR; r++) m_pend[w][r] = 0;
        m_ptr = NW - 1; m_win = -1; m_ov = '0; m_wid = '0; m_wb = 0; m_rd = '0; m_data = '0;
        m_issued = 0; m_scb = 0; m_unit = 0;
        exp_q.delete(); pq.delete();
    endtask

    task automatic clear_heads();
        for (int w = 0; w < NW; w++) begin
            v_valid[w] = 0; v_wb[w] = 0; v_rd[w] = '0; v_ex[w] = '0; v_data[w] = '0;
            for (int k = 0; k < 3; k++) begin v_rs[w][k] = '0; v_use[w][k] = 0; end
        end
    endtask

    task automatic set_head(input int w, input bit wb, input int rd, input int rs1,
                            input bit use1, input int ex);
        v_valid[w] = 1; v_wb[w] = wb; v_rd[w] = RW'(rd); v_ex[w] = EXW'(ex);
        v_data[w] = rnd128();
        v_rs[w][0] = RW'(rs1); v_use[w][0] = use1;
        for (int k = 1; k < 3; k++) begin v_rs[w][k] = '0; v_use[w][k] = 0; end
    endtask

    // Evaluate one cycle at the falling edge: check DUT against model, then advance model.
    task automatic model_cycle();
        logic [NW-1:0] exp_ready;
        bit free, haz, any_valid;
        int win, w, code;
        if (rst) begin
            check("rst_in_ready", in_ready, '0);
            check("rst_out_valid", out_valid, '0);
            check("rst_out_wid", out_wid, '0);
            check("rst_out_wb", out_wb, '0);
            check("rst_out_rd", out_rd, '0);
            check("rst_out_data", out_data, '0);
            model_reset();
            return;
        end
        free = (m_ov == '0) || ((m_ov & out_ready) != '0);
        win = -1; any_valid = 0;
        for (int i = 1; i <= NW; i++) begin
            w = (m_ptr + i) % NW;
            haz = 0;
            for (int k = 0; k < 3; k++)
                if (v_use[w][k] && v_rs[w][k] != 0 && m_pend[w][v_rs[w][k]]) haz = 1;
            if (v_wb[w] && v_rd[w] != 0 && m_pend[w][v_rd[w]]) haz = 1;
            if (v_valid[w]) any_valid = 1;
            if (win < 0 && v_valid[w] && !haz && free) win = w;
        end
        exp_ready = '0;
        if (win >= 0) exp_ready[win] = 1'b1;
        check("in_ready", in_ready, exp_ready);
        check("out_valid", out_valid, m_ov);
        check("out_wid", out_wid, m_wid);
        check("out_wb", out_wb, m_wb);
        check("out_rd", out_rd, m_rd);
        check("out_data", out_data, m_data);
        if ((out_valid & out_ready) != '0) begin
            check("sb_nonempty", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check("sb_data", out_data, exp_q.pop_front());
        end
        if (any_valid && free && win < 0) m_scb++;
        if (m_ov != '0 && (m_ov & out_ready) == '0) m_unit++;
        if (wb_valid && wb_eop) begin
            m_pend[wb_wid][wb_rd] = 0;
            code = int'(wb_wid) * NR + int'(wb_rd);
            for (int i = 0; i < pq.size(); i++)
                if (pq[i] == code) begin pq.delete(i); break; end
        end
        if (win >= 0) begin
            if (v_wb[win] && v_rd[win] != 0) begin
                m_pend[win][v_rd[win]] = 1;
                pq.push_back(win * NR + int'(v_rd[win]));
            end
            m_ptr = win;
            m_ov = '0; m_ov[v_ex[win]] = 1'b1;
            m_wid = WW'(win); m_wb = v_wb[win]; m_rd = v_rd[win]; m_data = v_data[win];
            exp_q.push_back(v_data[win]);
            m_issued++;
        end else if ((m_ov & out_ready) != '0) begin
            m_ov = '0;
        end
        m_win = win;
    endtask

    task automatic cycle();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic consume();
        if (m_win >= 0) v_valid[m_win] = 0;
    endtask

    task automatic idle(input int n);
        clear_heads();
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int idx;
        checks = 0; errors = 0;
        rst = 1; wb_valid = 0; wb_wid = '0; wb_rd = '0; wb_eop = 0; out_ready = '1;
        clear_heads(); model_reset();

        // Reset: heads present but nothing accepted.
        @(posedge clk); #1;
        for (int w = 0; w < NW; w++) set_head(w, 0, 0, 0, 0, w);
        #1 check("rst_hold_ready", in_ready, '0);
        cycle();
        rst = 0;

        // Round robin 0,1,2,3,0 with one-cycle latency.
        for (int k = 0; k < 5; k++) begin
            cycle();
            #1;
            check("rr_order", out_wid, order[k]);
            check("rr_pulse", out_valid, NE'(1) << order[k]);
            set_head(m_win, 0, 0, 0, 0, m_win);
        end
        idle(2);

        // Read-after-write on warp 1 register 5.
        set_head(1, 1, 5, 0, 0, 1);
        cycle(); consume();
        set_head(1, 0, 0, 5, 1, 2);
        set_head(0, 0, 0, 0, 0, 0);
        set_head(2, 0, 0, 0, 0, 2);
        for (int i = 0; i < 3; i++) begin
            #1 check("raw_blocked", in_ready[1], 1'b0);
            cycle();
            if (m_win != 1) consume();
        end
        wb_valid = 1; wb_wid = 2'd1; wb_rd = 6'd5; wb_eop = 0;
        #1 check("raw_no_eop", in_ready[1], 1'b0);
        cycle();
        wb_eop = 1;
        #1 check("raw_eop_cycle", in_ready[1], 1'b0);
        cycle();
        wb_valid = 0; wb_eop = 0;
        #1 check("raw_release", in_ready[1], 1'b1);
        cycle(); consume();
        #1 check("raw_issue_wid", out_wid, 1);
        check("raw_issue_unit", out_valid, NE'(4));
        idle(2);

        // Register 0 is never pending.
        set_head(2, 1, 0, 0, 0, 4);
        #1 check("r0_wb", in_ready[2], 1'b1);
        cycle(); consume();
        set_head(2, 1, 0, 0, 1, 4);
        #1 check("r0_src", in_ready[2], 1'b1);
        cycle(); consume();
        idle(2);

        // Head-of-line: unit 3 stalls for four cycles.
        out_ready = 5'b10111;
        set_head(0, 0, 0, 0, 0, 3);
        held = v_data[0];
        cycle(); consume();
        set_head(1, 0, 0, 0, 0, 1);
        set_head(2, 0, 0, 0, 0, 2);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("hol_ready", in_ready, '0);
            check("hol_valid", out_valid, NE'(8));
            check("hol_data", out_data, held);
            cycle();
        end
        out_ready = '1;
        #1 check("hol_reload", in_ready, NW'(2));
        cycle(); consume();
        #1 check("hol_next_wid", out_wid, 1);
        idle(3);

        // Write-after-write on warp 0 register 7.
        set_head(0, 1, 7, 0, 0, 0);
        cycle(); consume();
        set_head(0, 1, 7, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            #1 check("waw_blocked", in_ready[0], 1'b0);
            cycle();
        end
        wb_valid = 1; wb_wid = 2'd0; wb_rd = 6'd7; wb_eop = 1;
        #1 check("waw_eop_cycle", in_ready[0], 1'b0);
        cycle();
        wb_valid = 0; wb_eop = 0;
        #1 check("waw_release", in_ready[0], 1'b1);
        cycle(); consume();
        idle(2);

        // Reset mid-operation drops the slot and the scoreboard.
        set_head(3, 1, 9, 0, 0, 1);
        cycle(); consume();
        set_head(3, 0, 0, 9, 1, 2);
        rst = 1;
        #1;
        check("mid_rst_valid", out_valid, '0);
        check("mid_rst_data", out_data, '0);
        check("mid_rst_ready", in_ready, '0);
        cycle();
        rst = 0;
        #1 check("mid_rst_pend_lost", in_ready[3], 1'b1);
        cycle(); consume();
        idle(2);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            for (int w = 0; w < NW; w++) begin
                if (!v_valid[w] && $urandom_range(0, 2) != 0) begin
                    set_head(w, 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                             $urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, NE-1));
                    for (int k = 1; k < 3; k++) begin
                        v_rs[w][k] = RW'($urandom_range(0, 7));
                        v_use[w][k] = 1'($urandom_range(0, 1));
                    end
                end
            end
            out_ready = NE'($urandom);
            if (pq.size() > 0 && $urandom_range(0, 2) == 0) begin
                idx = $urandom_range(0, pq.size() - 1);
                wb_valid = 1;
                wb_wid = WW'(pq[idx] / NR);
                wb_rd = RW'(pq[idx] % NR);
                wb_eop = ($urandom_range(0, 3) != 0);
            end else begin
                wb_valid = 0; wb_eop = 0;
            end
            cycle(); consume();
        end

        wb_valid = 0; wb_eop = 0; out_ready = '1;
        idle(3);
        check("sb_drained", exp_q.size(), 0);
`ifdef VX_ISSUE_SCHED_PERF_EN
        check("perf_issued", perf_issued, m_issued[PB-1:0]);
        check("perf_scb_stalls", perf_scb_stalls, m_scb[PB-1:0]);
        check("perf_unit_stalls", perf_unit_stalls, m_unit[PB-1:0]);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
